// File: rtl/periph_map_pkg.sv
// rtl/periph_map_pkg.sv - address map, window codes and ID constants for the peripheral subsystem
package periph_map_pkg;

  localparam logic [19:0] BASE_HI  = 20'h02000;

  localparam logic [3:0]  WIN_DOUT = 4'h0;
  localparam logic [3:0]  WIN_CREG = 4'h1;
  localparam logic [3:0]  WIN_DIN  = 4'h8;

  localparam logic [7:0]  OFF_VER1 = 8'h00;
  localparam logic [7:0]  OFF_VER2 = 8'h04;
  localparam logic [7:0]  OFF_VER3 = 8'h08;

  localparam logic [31:0] ID_VER1_DEF = 32'h0123_4567;
  localparam logic [31:0] ID_VER2_DEF = 32'h89AB_CDEF;
  localparam logic [31:0] ID_VER3_DEF = 32'hFEDC_BA98;

  typedef struct packed {
    logic dout;
    logic creg;
    logic din;
    logic def;
  } sel_t;

  // Word-aligned lookup: the byte-lane bits are not part of the offset.
  function automatic logic [31:0] const_lookup(input logic [5:0] word_off,
                                               input logic [31:0] v1,
                                               input logic [31:0] v2,
                                               input logic [31:0] v3);
    logic [7:0] off;
    off = {word_off, 2'b00};
    if (off == OFF_VER1)      return v1;
    else if (off == OFF_VER2) return v2;
    else if (off == OFF_VER3) return v3;
    else                      return 32'h0;
  endfunction

endpackage

// File: rtl/periph_const_din_subsys_if.sv
// rtl/periph_const_din_subsys_if.sv - STB/WE/ACK slave bus between the SoC master and the subsystem
interface periph_bus_if;
  logic [31:0] iADR;
  logic        iSTB;
  logic        iWE;
  logic [31:0] oDAT;
  logic        oACK;

  modport master (output iADR, output iSTB, output iWE, input oDAT, input oACK);
  modport slave  (input iADR, input iSTB, input iWE, output oDAT, output oACK);
endinterface

// File: rtl/periph_addr_dec.sv
// rtl/periph_addr_dec.sv - combinational one-hot strobe decode; unmapped hits go to the default slave
import periph_map_pkg::*;

module periph_addr_dec (
  input  logic [31:0] i_adr,
  input  logic        i_stb,
  output sel_t        o_sel
);

  always_comb begin
    o_sel = '0;
    if (i_stb) begin
      if (i_adr[31:12] != BASE_HI) begin
        o_sel.def = 1'b1;
      end else begin
        case (i_adr[11:8])
          WIN_DOUT: o_sel.dout = 1'b1;
          WIN_CREG: o_sel.creg = 1'b1;
          WIN_DIN:  o_sel.din  = 1'b1;
          default:  o_sel.def  = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/periph_const_reg.sv
// rtl/periph_const_reg.sv - read-only ID bank; writes are acknowledged and discarded
import periph_map_pkg::*;

module periph_const_reg #(
  parameter logic [31:0] ID_VER1 = ID_VER1_DEF,
  parameter logic [31:0] ID_VER2 = ID_VER2_DEF,
  parameter logic [31:0] ID_VER3 = ID_VER3_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb,
  input  logic [5:0]  i_word_off,
  output logic        o_ack,
  output logic [31:0] o_dat
);

  logic        r_ack;
  logic [31:0] r_dat;
  logic        w_take;

  // A held strobe is served every other cycle because the ACK masks the next sample.
  assign w_take = i_stb & ~r_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_take;
      r_dat <= w_take ? const_lookup(i_word_off, ID_VER1, ID_VER2, ID_VER3) : '0;
    end
  end

  assign o_ack = r_ack;
  assign o_dat = r_dat;

endmodule

// File: rtl/periph_din_port.sv
// rtl/periph_din_port.sv - 8-bit digital input port with free-running two-flop synchronizer
module periph_din_port (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stb,
  input  logic [7:0]  i_din,
  output logic        o_ack,
  output logic [31:0] o_dat
);

  logic [7:0]  r_sync1;
  logic [7:0]  r_sync2;
  logic        r_ack;
  logic [31:0] r_dat;
  logic        w_take;

  assign w_take = i_stb & ~r_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      r_ack   <= w_take;
      r_dat   <= w_take ? {24'h0, r_sync2} : '0;
    end
  end

  assign o_ack = r_ack;
  assign o_dat = r_dat;

endmodule

// File: rtl/periph_const_din_subsys.sv
// rtl/periph_const_din_subsys.sv - decoder, ID bank, input port, default slave and read-data/ACK merge
import periph_map_pkg::*;

module periph_const_din_subsys #(
  parameter logic [31:0] ID_VER1 = ID_VER1_DEF,
  parameter logic [31:0] ID_VER2 = ID_VER2_DEF,
  parameter logic [31:0] ID_VER3 = ID_VER3_DEF
) (
  input  logic         iCLK,
  input  logic         iRST,
  periph_bus_if.slave  bus,
  input  logic [7:0]   iDIn,
  input  logic [31:0]  iDAT_OutPort,
  input  logic         iACK_OutPort,
  output logic         oSTB_DigOutPort
);

  sel_t        w_sel;
  logic        w_ack_creg;
  logic [31:0] w_dat_creg;
  logic        w_ack_din;
  logic [31:0] w_dat_din;
  logic        r_ack_def;

  periph_addr_dec u_dec (
    .i_adr (bus.iADR),
    .i_stb (bus.iSTB),
    .o_sel (w_sel)
  );

  periph_const_reg #(
    .ID_VER1 (ID_VER1),
    .ID_VER2 (ID_VER2),
    .ID_VER3 (ID_VER3)
  ) u_creg (
    .i_clk      (iCLK),
    .i_rst      (iRST),
    .i_stb      (w_sel.creg),
    .i_word_off (bus.iADR[7:2]),
    .o_ack      (w_ack_creg),
    .o_dat      (w_dat_creg)
  );

  periph_din_port u_din (
    .i_clk (iCLK),
    .i_rst (iRST),
    .i_stb (w_sel.din),
    .i_din (iDIn),
    .o_ack (w_ack_din),
    .o_dat (w_dat_din)
  );

  // Default slave only acknowledges; its read data is constant zero.
  always_ff @(posedge iCLK) begin
    if (iRST) r_ack_def <= 1'b0;
    else      r_ack_def <= w_sel.def & ~r_ack_def;
  end

  assign oSTB_DigOutPort = w_sel.dout;

  assign bus.oACK = iACK_OutPort | w_ack_creg | w_ack_din | r_ack_def;
  assign bus.oDAT = (iDAT_OutPort & {32{iACK_OutPort}})
                  | (w_dat_creg   & {32{w_ack_creg}})
                  | (w_dat_din    & {32{w_ack_din}});

endmodule

// File: tb/tb_periph_const_din_subsys.sv
// tb/tb_periph_const_din_subsys.sv - scoreboard bench with a behavioural address-map model
module tb_periph_const_din_subsys;

  localparam logic [31:0] V1 = 32'h0123_4567;
  localparam logic [31:0] V2 = 32'h89AB_CDEF;
  localparam logic [31:0] V3 = 32'hFEDC_BA98;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic [31:0] dat_out;
  logic        ack_out;
  logic        stb_out;

  periph_bus_if bus ();

  periph_const_din_subsys dut (
    .iCLK            (clk),
    .iRST            (rst),
    .bus             (bus),
    .iDIn            (din),
    .iDAT_OutPort    (dat_out),
    .iACK_OutPort    (ack_out),
    .oSTB_DigOutPort (stb_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    bit          chk;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] cur_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [7:0] d);
    logic [7:0] off;
    if (a[31:12] != 20'h02000) return 32'h0;
    off = a[7:0] & 8'hFC;
    case (a[11:8])
      4'h1: begin
        if (off == 8'h00)      return V1;
        else if (off == 8'h04) return V2;
        else if (off == 8'h08) return V3;
        else                   return 32'h0;
      end
      4'h8:    return {24'h0, d};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_dout(input logic [31:0] a);
    return (a[31:12] == 20'h02000) && (a[11:8] == 4'h0);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    check("stb_digout", {31'h0, stb_out}, {31'h0, bus.iSTB && is_dout(bus.iADR)});
    if (bus.oACK) begin
      if (q.size() == 0) begin
        check("unexpected_ack", {31'h0, bus.oACK}, 32'h0);
      end else begin
        e = q.pop_front();
        if (e.chk) check("read_data", bus.oDAT, e.dat);
      end
    end
  end

  task automatic int_access(input logic [31:0] a, input bit we, input bit chk, input logic [31:0] exp);
    @(posedge clk); #1;
    q.push_back('{exp, chk});
    bus.iADR = a;
    bus.iWE  = we;
    bus.iSTB = 1'b1;
    @(posedge clk); #1;
    bus.iSTB = 1'b0;
    bus.iWE  = 1'b0;
  endtask

  task automatic ext_access(input logic [31:0] a, input bit we, input logic [31:0] d);
    @(posedge clk); #1;
    bus.iADR = a;
    bus.iWE  = we;
    bus.iSTB = 1'b1;
    @(posedge clk); #1;
    q.push_back('{d, 1'b1});
    ack_out = 1'b1;
    dat_out = d;
    @(posedge clk); #1;
    ack_out  = 1'b0;
    dat_out  = '0;
    bus.iSTB = 1'b0;
    bus.iWE  = 1'b0;
  endtask

  task automatic set_din(input logic [7:0] v);
    @(posedge clk); #1;
    din = v;
    cur_din = v;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int          kind;
    bit          we;

    rst = 1'b1; din = '0; cur_din = '0; dat_out = '0; ack_out = 1'b0;
    bus.iADR = '0; bus.iSTB = 1'b0; bus.iWE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack", {31'h0, bus.oACK}, 32'h0);
    check("reset_dat", bus.oDAT, 32'h0);
    check("reset_stb", {31'h0, stb_out}, 32'h0);
    rst = 1'b0;

    int_access(32'h0200_0100, 1'b0, 1'b1, V1);
    int_access(32'h0200_0104, 1'b0, 1'b1, V2);
    int_access(32'h0200_0108, 1'b0, 1'b1, V3);
    int_access(32'h0200_010C, 1'b0, 1'b1, 32'h0);
    int_access(32'h0200_0107, 1'b0, 1'b1, V2);

    @(posedge clk); #1;
    din = 8'hCD; cur_din = 8'hCD;
    repeat (5) @(posedge clk);
    int_access(32'h0200_0800, 1'b0, 1'b1, 32'h0000_00CD);
    @(posedge clk); #1;
    din = 8'h3A; cur_din = 8'h3A;
    int_access(32'h0200_0800, 1'b0, 1'b1, 32'h0000_00CD);
    repeat (2) @(posedge clk);
    int_access(32'h0200_0844, 1'b0, 1'b1, 32'h0000_003A);

    ext_access(32'h0200_0000, 1'b1, 32'h0000_0012);

    int_access(32'h0200_0104, 1'b1, 1'b0, 32'h0);
    int_access(32'h0200_0104, 1'b0, 1'b1, V2);
    int_access(32'h0200_0400, 1'b0, 1'b1, 32'h0);
    int_access(32'h0300_0000, 1'b0, 1'b1, 32'h0);
    int_access(32'h0300_0000, 1'b1, 1'b1, 32'h0);

    // Held strobe on the ID bank: ACKs on the 1st and 3rd sampled cycles.
    @(posedge clk); #1;
    q.push_back('{V2, 1'b1});
    q.push_back('{V2, 1'b1});
    bus.iADR = 32'h0200_0104;
    bus.iSTB = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.iSTB = 1'b0;
    @(posedge clk);

    // Reset coincident with the edge that would raise the ACK.
    @(posedge clk); #1;
    bus.iADR = 32'h0200_0100;
    bus.iSTB = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_ack", {31'h0, bus.oACK}, 32'h0);
    bus.iSTB = 1'b0;
    rst = 1'b0;
    cur_din = '0;
    set_din(din);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      we   = 1'($urandom_range(0, 1));
      case (kind)
        0: begin
          a = 32'h0200_0100 | ($urandom & 32'h1F);
          int_access(a, we, !we, model(a, cur_din));
        end
        1: begin
          set_din(8'($urandom));
          a = 32'h0200_0800 | ($urandom & 32'hFF);
          int_access(a, we, !we, model(a, cur_din));
        end
        2: begin
          a = $urandom;
          if (a[31:12] == 20'h02000) a[11:8] = 4'h5;
          int_access(a, we, 1'b1, model(a, cur_din));
        end
        default: begin
          a = 32'h0200_0000 | ($urandom & 32'hFF);
          d = $urandom;
          ext_access(a, we, d);
        end
      endcase
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_empty", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
